// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, FSM state type and phase constants for the CORDIC phase generator.
package cordic_pkg;
    localparam int PHASE_W_DEF = 20;
    localparam int CNT_W_DEF   = 16;
    localparam int QUARTER     = 1 << (PHASE_W_DEF - 2);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cordic_phase_fold.sv
// cordic_phase_fold: folds a binary angle into [-90deg,+90deg) and flags it for output negation.
module cordic_phase_fold #(
    parameter int W = 20
) (
    input  logic [W-1:0] phase_i,
    output logic [W-1:0] angle_o,
    output logic         negate_o
);
    // Quadrants 2 and 3 (top bits 01/10) shift by 180deg; the sign flip is undone downstream.
    assign negate_o = phase_i[W-1] ^ phase_i[W-2];
    assign angle_o  = negate_o ? {~phase_i[W-1], phase_i[W-2:0]} : phase_i;
endmodule

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: burst/continuous phase accumulator feeding the CORDIC with folded angles.
// Define CORDIC_PHASE_DITHER_EN to add 4-bit LFSR dither to each phase before folding.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [PHASE_W-1:0] step_i,
    input  logic [PHASE_W-1:0] phase0_i,
    input  logic [CNT_W-1:0]   count_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PHASE_W-1:0] angle_o,
    output logic               negate_o,
    output logic               last_o,
    output logic               busy_o,
    output logic               done_o
);
    state_e             state_q, state_d;
    logic [PHASE_W-1:0] p_q, p_d, step_q, step_d, angle_q, fold_in, fold_angle;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               cont_q, cont_d, last_q, last_d, valid_q, valid_d, neg_q, fold_neg, hs;
`ifdef CORDIC_PHASE_DITHER_EN
    logic [7:0]         lfsr_q, lfsr_d;
`endif

    assign hs = valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        step_d  = step_q;
        rem_d   = rem_q;
        cont_d  = cont_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifdef CORDIC_PHASE_DITHER_EN
        lfsr_d  = lfsr_q;
`endif
        if (stop_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_d = RUN;
                    p_d     = phase0_i;
                    step_d  = step_i;
                    rem_d   = count_i;
                    cont_d  = count_i == '0;
                    last_d  = count_i == CNT_W'(1);
                    valid_d = 1'b1;
`ifdef CORDIC_PHASE_DITHER_EN
                    lfsr_d  = 8'h01;
`endif
                end
                RUN: if (hs) begin
                    state_d = last_q ? DONE : RUN;
                    valid_d = !last_q;
                    // rem_q still counts the sample just accepted, so 2 means the next one is final
                    last_d  = !last_q && !cont_q && rem_q == CNT_W'(2);
                    p_d     = p_q + step_q;
                    rem_d   = cont_q ? rem_q : rem_q - CNT_W'(1);
`ifdef CORDIC_PHASE_DITHER_EN
                    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef CORDIC_PHASE_DITHER_EN
    assign fold_in = p_d + PHASE_W'(lfsr_d[3:0]);
`else
    assign fold_in = p_d;
`endif

    cordic_phase_fold #(.W(PHASE_W)) u_fold (
        .phase_i  (fold_in),
        .angle_o  (fold_angle),
        .negate_o (fold_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            cont_q  <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            angle_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            cont_q  <= cont_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            angle_q <= fold_angle;
            neg_q   <= fold_neg;
        end
    end

`ifdef CORDIC_PHASE_DITHER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'h01;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign out_valid_o = valid_q;
    assign angle_o     = angle_q;
    assign negate_o    = neg_q;
    assign last_o      = last_q;
    assign busy_o      = state_q == RUN;
    assign done_o      = state_q == DONE;
endmodule
